// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: WIDTH-bit words in over valid/ready, MSB-first bits out on a registered line.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_active,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef BIT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shifter;
  logic [WIDTH-1:0] hold_data;
  logic [CW-1:0]    bit_cnt;
  logic             hold_full;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             parity_bit;
`endif

  logic             accept;
  logic             last_bit;
  logic             drain;
  logic             load_en;
  logic [WIDTH-1:0] load_word;

  assign in_ready = !hold_full;

  // last_bit marks the cycle whose closing edge ends the current word.
  always_comb begin
    accept = in_valid && !hold_full;
`ifdef BIT_SERIALIZER_PARITY_EN
    last_bit = (state == PARITY);
`else
    last_bit = (state == SHIFT) && (bit_cnt == '0);
`endif
    drain     = last_bit && hold_full;
    load_en   = drain || ((state == IDLE || last_bit) && accept);
    load_word = hold_full ? hold_data : in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shifter    <= '0;
      hold_data  <= '0;
      bit_cnt    <= '0;
      hold_full  <= 1'b0;
      ser_out    <= IDLE_BIT;
      ser_active <= 1'b0;
      word_done  <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      // An accept that does not start a word directly parks it in the hold register.
      if (accept && !load_en) begin
        hold_data <= in_data;
        hold_full <= 1'b1;
      end else if (drain) begin
        hold_full <= 1'b0;
      end

      if (load_en) begin
        state      <= SHIFT;
        shifter    <= load_word;
        bit_cnt    <= CW'(WIDTH - 1);
        ser_out    <= load_word[WIDTH-1];
        ser_active <= 1'b1;
        word_done  <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        parity_bit <= ^load_word;
`endif
      end else begin
        case (state)
          SHIFT: begin
            if (bit_cnt != '0) begin
              shifter <= {shifter[WIDTH-2:0], 1'b0};
              bit_cnt <= bit_cnt - CW'(1);
              ser_out <= shifter[WIDTH-2];
`ifdef BIT_SERIALIZER_PARITY_EN
              word_done <= 1'b0;
`else
              word_done <= (bit_cnt == CW'(1));
`endif
            end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
              state     <= PARITY;
              ser_out   <= parity_bit;
              word_done <= 1'b1;
`else
              state      <= IDLE;
              ser_out    <= IDLE_BIT;
              ser_active <= 1'b0;
              word_done  <= 1'b0;
`endif
            end
          end
          default: begin
            state      <= IDLE;
            ser_out    <= IDLE_BIT;
            ser_active <= 1'b0;
            word_done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: vector table plus streaming, idle, reset and detector sequences.
module tb_bit_serializer;

  localparam int   W        = 8;
  localparam logic IDLE_LVL = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int   FRAME  = W + 1;
  localparam bit   PAR_EN = 1'b1;
  localparam int   EXP_Z  = 3;
`else
  localparam int   FRAME  = W;
  localparam bit   PAR_EN = 1'b0;
  localparam int   EXP_Z  = 2;
`endif

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         ser_out;
  logic         ser_active;
  logic         word_done;

  bit_serializer #(.WIDTH(W), .IDLE_BIT(IDLE_LVL)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ser_out    (ser_out),
    .ser_active (ser_active),
    .word_done  (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic d;
  } sb_t;

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] bits;
    logic         par;
  } vec_t;

  sb_t  exp_q[$];
  sb_t  mon_e;
  vec_t vecs[5];

  int checks = 0;
  int passes = 0;

  logic       mon_en = 1'b0;
  logic       det_en = 1'b0;
  logic [1:0] hist = 2'b00;
  int         cyc = 0;
  int         run_len = 0;
  int         last_run = 0;
  int         done_cnt = 0;
  int         done_gap = 0;
  int         last_done_cyc = -1;
  int         det_cnt = 0;
  int         det_idx[4];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic pushWord(input logic [W-1:0] bits, input logic par);
    for (int i = W - 1; i >= 0; i--)
      exp_q.push_back('{b: bits[i], d: (i == 0) && !PAR_EN});
    if (PAR_EN) exp_q.push_back('{b: par, d: 1'b1});
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high.
  task automatic applyStimulus(input logic [W-1:0] data, input logic [W-1:0] bits, input logic par);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = data;
    for (int n = 0; n < 100 && !ok; n++) begin
      if (in_ready) begin
        @(posedge clk);
        pushWord(bits, par);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    checkOutput("accept_within_bound", ok, 1);
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 300 && (exp_q.size() != 0 || ser_active); n++) @(negedge clk);
    checkOutput("drain_within_bound", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Scoreboard monitor plus a 110 detector watching the line as the downstream X input.
  always @(negedge clk) begin
    cyc++;
    if (mon_en && reset_n) begin
      if (det_en && ser_active && hist == 2'b11 && ser_out == 1'b0) begin
        if (det_cnt < 4) det_idx[det_cnt] = run_len;
        det_cnt++;
      end
      hist = {hist[0], ser_out};
      if (ser_active) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_active", ser_active, 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("ser_out_bit", ser_out, mon_e.b);
          checkOutput("word_done_bit", word_done, mon_e.d);
        end
        if (word_done) begin
          if (last_done_cyc >= 0) done_gap = cyc - last_done_cyc;
          last_done_cyc = cyc;
          done_cnt++;
        end
        run_len++;
      end else begin
        checkOutput("idle_level", ser_out, IDLE_LVL);
        checkOutput("idle_no_done", word_done, 0);
        if (run_len > 0) last_run = run_len;
        run_len = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d passed %0d", checks, passes);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{data: 8'hC6, bits: 8'b11000110, par: 1'b0};
    vecs[1] = '{data: 8'h07, bits: 8'b00000111, par: 1'b1};
    vecs[2] = '{data: 8'hA5, bits: 8'b10100101, par: 1'b0};
    vecs[3] = '{data: 8'h80, bits: 8'b10000000, par: 1'b1};
    vecs[4] = '{data: 8'h01, bits: 8'b00000001, par: 1'b1};

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ser_out", ser_out, IDLE_LVL);
    checkOutput("reset_active", ser_active, 0);
    checkOutput("reset_done", word_done, 0);
    checkOutput("reset_ready", in_ready, 1);
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    $display("[TB] single-word vectors");
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].data, vecs[v].bits, vecs[v].par);
      in_valid = 1'b0;
      in_data  = ~vecs[v].data;
      checkOutput("first_bit_active", ser_active, 1);
      checkOutput("first_bit_msb", ser_out, vecs[v].bits[W-1]);
      waitDrain();
      checkOutput("post_word_idle", ser_active, 0);
      checkOutput("post_word_run_len", last_run, FRAME);
    end

    $display("[TB] streaming three words");
    done_cnt      = 0;
    last_done_cyc = -1;
    applyStimulus(8'hA5, 8'b10100101, 1'b0);
    checkOutput("ready_after_1st", in_ready, 1);
    applyStimulus(8'h3C, 8'b00111100, 1'b0);
    checkOutput("ready_low_after_2nd", in_ready, 0);
    applyStimulus(8'hFF, 8'b11111111, 1'b0);
    checkOutput("ready_low_after_3rd", in_ready, 0);
    in_valid = 1'b0;
    waitDrain();
    checkOutput("stream_contiguous_bits", last_run, 3 * FRAME);
    checkOutput("stream_done_count", done_cnt, 3);
    checkOutput("stream_done_spacing", done_gap, FRAME);

    $display("[TB] idle line");
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      checkOutput("idle_ser_out", ser_out, IDLE_LVL);
      checkOutput("idle_active", ser_active, 0);
      checkOutput("idle_ready", in_ready, 1);
    end

    $display("[TB] reset mid-word");
    applyStimulus(8'hF0, 8'b11110000, 1'b0);
    applyStimulus(8'h0F, 8'b00001111, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_ser_out", ser_out, IDLE_LVL);
    checkOutput("midreset_active", ser_active, 0);
    checkOutput("midreset_done", word_done, 0);
    checkOutput("midreset_ready", in_ready, 1);
    exp_q.delete();
    run_len = 0;
    hist    = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      checkOutput("no_ghost_bits", ser_active, 0);
    end
    applyStimulus(8'hC6, 8'b11000110, 1'b0);
    in_valid = 1'b0;
    waitDrain();
    checkOutput("recovery_run_len", last_run, FRAME);

    $display("[TB] 110 detector on 0xDB");
    det_cnt = 0;
    det_en  = 1'b1;
    applyStimulus(8'hDB, 8'b11011011, 1'b0);
    in_valid = 1'b0;
    waitDrain();
    det_en = 1'b0;
    checkOutput("detector_pulses", det_cnt, EXP_Z);
    checkOutput("detector_first_pos", det_idx[0], 2);
    checkOutput("detector_second_pos", det_idx[1], 5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
